// File: rtl/dffarb_pkg.sv
// Shared types and helpers for the round-robin storage-register arbiter.
//   state_t : arbiter FSM states (IDLE, HOLD)
//   idw()   : index width for a count of n items (minimum 1 bit)
package dffarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N.
// Ports:
//   req     in  N    request vector
//   ptr     in  IDW  starting position of the scan
//   onehot  out N    one-hot winner (zero when no request)
//   idx     out IDW  winner index (zero when no request)
//   any_req out 1    at least one request is set
module rr_pick
  import dffarb_pkg::*;
#(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           any_req
);

  logic found;

  // Rotating scan; the first hit in scan order wins so onehot stays single-hot.
  always_comb begin
    onehot  = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      if (!found && req[(32'(ptr) + off) % N]) begin
        found                       = 1'b1;
        onehot[(32'(ptr) + off) % N] = 1'b1;
        idx                         = IDW'((32'(ptr) + off) % N);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one W-bit storage register among N requesters.
// A winner loads its word into q and owns it for up to HOLD_CYCLES cycles;
// one IDLE cycle always separates consecutive grants.
// Optional build macro: PRIORITY0_EN -- requester 0 wins whenever it requests
// and does not advance the round-robin pointer.
// Ports:
//   clock   in  1     rising-edge clock
//   reset_n in  1     asynchronous active-low reset
//   req     in  N     level requests, held until grant seen
//   wdata   in  N*W   requester i word at [i*W +: W]
//   gnt     out N     one-hot grant (registered)
//   q       out W     shared register contents
//   owner   out IDW   current/last winner index
//   busy    out 1     grant active
module dff_bank_arbiter
  import dffarb_pkg::*;
#(
  parameter  int unsigned N           = 4,
  parameter  int unsigned W           = 8,
  parameter  int unsigned HOLD_CYCLES = 2,
  localparam int unsigned IDW         = idw(N)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic [IDW-1:0] owner,
  output logic           busy
);

  localparam int unsigned CW = idw(HOLD_CYCLES);

  // Parameter legality
  if (N < 2 || N > 16) begin : g_bad_n
    $error("dff_bank_arbiter: N must be in 2..16");
  end
  if (W < 1) begin : g_bad_w
    $error("dff_bank_arbiter: W must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("dff_bank_arbiter: HOLD_CYCLES must be >= 1");
  end

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [N-1:0]   gnt_n;
  logic [W-1:0]   q_n;
  logic [IDW-1:0] owner_n;
  logic           busy_n;

  logic [N-1:0]   pick_onehot, win_onehot;
  logic [IDW-1:0] pick_idx, win_idx, next_ptr;
  logic           any_req;
  logic [W-1:0]   words [N];

  // Unpack the flat data bus into per-requester words
  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = wdata[i*W +: W];
  end

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .any_req (any_req)
  );

  // Winner selection and pointer advance (optionally overridden by requester 0)
  always_comb begin
    win_onehot = pick_onehot;
    win_idx    = pick_idx;
    next_ptr   = (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + IDW'(1);
`ifdef PRIORITY0_EN
    if (req[0]) begin
      win_onehot = N'(1);
      win_idx    = '0;
      next_ptr   = ptr;
    end
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ptr_n   = ptr;
    gnt_n   = gnt;
    q_n     = q;
    owner_n = owner;
    busy_n  = busy;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n = HOLD;
          gnt_n   = win_onehot;
          owner_n = win_idx;
          q_n     = words[win_idx];
          busy_n  = 1'b1;
          cnt_n   = CW'(HOLD_CYCLES - 1);
          ptr_n   = next_ptr;
        end
      end
      HOLD: begin
        // Owner dropping its request ends the grant early
        if (cnt == '0 || !req[owner]) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      q     <= '0;
      owner <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      q     <= q_n;
      owner <= owner_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter (N=4, W=8, HOLD_CYCLES=2).
// Stimulus pushes expected grants; a negedge monitor pops and checks them.
module tb_dff_bank_arbiter;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    int unsigned len;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  dff_bank_arbiter #(.N(4), .W(8), .HOLD_CYCLES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .owner   (owner),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_grant(input logic [3:0] g, input logic [1:0] o,
                              input logic [7:0] d, input int unsigned len);
    exp_t e;
    e.gnt = g; e.owner = o; e.q = d; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: checks each new grant, its stability while held, and its length
  logic [3:0]  prev_gnt = '0;
  exp_t        cur;
  int unsigned hold_len = 0;

  always @(negedge clock) begin
    check("busy_vs_gnt", 32'(busy), 32'(gnt != 4'b0));
    if (gnt != 4'b0 && prev_gnt == 4'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(gnt), 32'(0));
        cur = '0;
      end else begin
        cur = exp_q.pop_front();
        check("grant_gnt", 32'(gnt), 32'(cur.gnt));
        check("grant_owner", 32'(owner), 32'(cur.owner));
        check("grant_q", 32'(q), 32'(cur.q));
      end
      hold_len = 1;
    end else if (gnt != 4'b0) begin
      hold_len++;
      check("held_gnt", 32'(gnt), 32'(cur.gnt));
      check("held_q_frozen", 32'(q), 32'(cur.q));
    end else if (prev_gnt != 4'b0) begin
      check("grant_len", hold_len, cur.len);
    end
    prev_gnt = gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req     = 4'b0;
    wdata   = 32'h0;
    cyc(2);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_q", 32'(q), 32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    reset_n = 1'b1;
    cyc(1);

    // Single request, wdata change during HOLD must be ignored
    req = 4'b0001; wdata[7:0] = 8'hA5;
    expect_grant(4'b0001, 2'd0, 8'hA5, 2);
    cyc(1);
    wdata[7:0] = 8'hFF;
    cyc(2);
    check("single_release_busy", 32'(busy), 32'(0));
    req = 4'b0;
    cyc(1);
    check("idle_gnt", 32'(gnt), 32'(0));
    check("idle_q_kept", 32'(q), 32'hA5);
    check("idle_owner_kept", 32'(owner), 32'(0));

    // Asynchronous reset mid-HOLD
    req = 4'b0010; wdata[15:8] = 8'h33;
    expect_grant(4'b0010, 2'd1, 8'h33, 1);
    cyc(1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'(0));
    check("async_rst_q", 32'(q), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    check("async_rst_owner", 32'(owner), 32'(0));
    req = 4'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // Fairness with all four requesting from ptr=0
    req = 4'b1111; wdata = 32'h13121110;
`ifdef PRIORITY0_EN
    for (int i = 0; i < 5; i++) expect_grant(4'b0001, 2'd0, 8'h10, 2);
`else
    expect_grant(4'b0001, 2'd0, 8'h10, 2);
    expect_grant(4'b0010, 2'd1, 8'h11, 2);
    expect_grant(4'b0100, 2'd2, 8'h12, 2);
    expect_grant(4'b1000, 2'd3, 8'h13, 2);
    expect_grant(4'b0001, 2'd0, 8'h10, 2);
`endif
    cyc(15);
    req = 4'b0;
    cyc(2);

    // Early release after one HOLD cycle
    req = 4'b0100; wdata[23:16] = 8'h77;
    expect_grant(4'b0100, 2'd2, 8'h77, 1);
    cyc(1);
    req = 4'b0;
    cyc(1);
    check("early_release_busy", 32'(busy), 32'(0));
    cyc(1);

    // Wrap-around: ptr=3 with req 1001
    req = 4'b1001; wdata[31:24] = 8'h39; wdata[7:0] = 8'h90;
`ifdef PRIORITY0_EN
    expect_grant(4'b0001, 2'd0, 8'h90, 2);
    expect_grant(4'b0001, 2'd0, 8'h90, 1);
`else
    expect_grant(4'b1000, 2'd3, 8'h39, 2);
    expect_grant(4'b0001, 2'd0, 8'h90, 1);
`endif
    cyc(4);
    req = 4'b0;
    cyc(2);

`ifdef PRIORITY0_EN
    // Move ptr to 2, then requester 0 preempts the scan without moving ptr
    req = 4'b0010; wdata[15:8] = 8'h61;
    expect_grant(4'b0010, 2'd1, 8'h61, 1);
    cyc(1);
    req = 4'b0;
    cyc(2);
    req = 4'b0101; wdata[7:0] = 8'h50; wdata[23:16] = 8'h52;
    expect_grant(4'b0001, 2'd0, 8'h50, 1);
    expect_grant(4'b0100, 2'd2, 8'h52, 2);
    cyc(1);
    req = 4'b0100;
    cyc(4);
    req = 4'b0;
    cyc(2);
`endif

    cyc(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
